// File: rtl/vga_sync_gen_if.sv
// Pixel-coordinate interface between the raster timing source (master)
// and the text/clock display that consumes it (slave).
interface vga_sync_gen_if;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       p_tick;
    logic       video_on;
    logic       hsync_n;
    logic       vsync_n;
    logic       frame_start;

    modport master (
        output pix_x, pix_y, p_tick, video_on, hsync_n, vsync_n, frame_start
    );

    modport slave (
        input pix_x, pix_y, p_tick, video_on, hsync_n, vsync_n, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing source: pixel-rate divider, h/v counters and sync decode.
// Optional macro SYNC_PIPE_EN delays video_on/hsync_n/vsync_n by one pixel.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    vga_sync_gen_if.master vga
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_DISP   = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISP   = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_q;
    logic [9:0]       x_q, y_q;
    logic [9:0]       x_nxt, y_nxt;
    logic             tick;
    logic             video_q, hsync_q, vsync_q, frame_q;
    logic             video_d, hsync_d, vsync_d;

    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    always_comb begin
        x_nxt = x_q + 10'd1;
        y_nxt = y_q;
        if (x_q == H_LAST) begin
            x_nxt = '0;
            y_nxt = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
        end
    end

    // Decode from the next counter values so the registered flags line up with pix_x/pix_y.
    always_comb begin
        video_d = (x_nxt < H_DISP) && (y_nxt < V_DISP);
        hsync_d = !((x_nxt >= HS_START) && (x_nxt <= HS_END));
        vsync_d = !((y_nxt >= VS_START) && (y_nxt <= VS_END));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q     <= '0;
            y_q     <= '0;
            video_q <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            frame_q <= tick && (x_q == H_LAST) && (y_q == V_LAST);
            if (tick) begin
                x_q     <= x_nxt;
                y_q     <= y_nxt;
                video_q <= video_d;
                hsync_q <= hsync_d;
                vsync_q <= vsync_d;
            end
        end
    end

`ifdef SYNC_PIPE_EN
    logic video_p, hsync_p, vsync_p;

    // One-pixel lag to match the registered font ROM and colour stage downstream.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            video_p <= 1'b0;
            hsync_p <= 1'b1;
            vsync_p <= 1'b1;
        end else if (tick) begin
            video_p <= video_q;
            hsync_p <= hsync_q;
            vsync_p <= vsync_q;
        end
    end

    assign vga.video_on = video_p;
    assign vga.hsync_n  = hsync_p;
    assign vga.vsync_n  = vsync_p;
`else
    assign vga.video_on = video_q;
    assign vga.hsync_n  = hsync_q;
    assign vga.vsync_n  = vsync_q;
`endif

    assign vga.pix_x       = x_q;
    assign vga.pix_y       = y_q;
    assign vga.p_tick      = tick;
    assign vga.frame_start = frame_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen with a reduced raster so whole frames fit in a short run.
module tb_vga_sync_gen;
    localparam int CLK_DIV   = 3;
    localparam int H_DISPLAY = 10;
    localparam int H_FRONT   = 2;
    localparam int H_SYNC    = 3;
    localparam int H_BACK    = 2;
    localparam int V_DISPLAY = 6;
    localparam int V_FRONT   = 1;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 2;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int FRAME     = H_TOTAL * V_TOTAL;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    vga_sync_gen_if vga ();

    vga_sync_gen #(
        .CLK_DIV(CLK_DIV), .H_DISPLAY(H_DISPLAY), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC),
        .H_BACK(H_BACK), .V_DISPLAY(V_DISPLAY), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC),
        .V_BACK(V_BACK)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .vga   (vga)
    );

    always #5 clk_i = ~clk_i;

    int     checks = 0;
    int     errors = 0;
    longint n      = 0;  // clk_i rising edges since reset release

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (n=%0d)", tag, obs, exp, n);
        end
    endtask

    // Reference: position is simply the number of elapsed pixel ticks modulo the frame size.
    task automatic check_model(input string tag);
        longint ticks;
        int     k, kd, x, y, xd, yd;
        logic   e_tick, e_fs, e_vid, e_hs, e_vs;
        ticks  = n / CLK_DIV;
        k      = int'(ticks % FRAME);
        x      = k % H_TOTAL;
        y      = k / H_TOTAL;
        e_tick = (n % CLK_DIV) == CLK_DIV - 1;
        e_fs   = (ticks > 0) && ((n % CLK_DIV) == 0) && (k == 0);
        e_vid  = 1'b0;
        e_hs   = 1'b1;
        e_vs   = 1'b1;
`ifdef SYNC_PIPE_EN
        if (ticks >= 2) begin
            kd = (k + FRAME - 1) % FRAME;
`else
        if (ticks >= 1) begin
            kd = k;
`endif
            xd    = kd % H_TOTAL;
            yd    = kd / H_TOTAL;
            e_vid = (xd < H_DISPLAY) && (yd < V_DISPLAY);
            e_hs  = !((xd >= H_DISPLAY + H_FRONT) && (xd < H_DISPLAY + H_FRONT + H_SYNC));
            e_vs  = !((yd >= V_DISPLAY + V_FRONT) && (yd < V_DISPLAY + V_FRONT + V_SYNC));
        end
        chk({tag, ".pix_x"},       vga.pix_x,       10'(x));
        chk({tag, ".pix_y"},       vga.pix_y,       10'(y));
        chk({tag, ".p_tick"},      10'(vga.p_tick),      10'(e_tick));
        chk({tag, ".frame_start"}, 10'(vga.frame_start), 10'(e_fs));
        chk({tag, ".video_on"},    10'(vga.video_on),    10'(e_vid));
        chk({tag, ".hsync_n"},     10'(vga.hsync_n),     10'(e_hs));
        chk({tag, ".vsync_n"},     10'(vga.vsync_n),     10'(e_vs));
    endtask

    task automatic step(input string tag);
        @(negedge clk_i);
        n++;
        check_model(tag);
    endtask

    initial begin
        int tick_cnt, hs_low, vs_low, fs_cnt, len, hold;

        // Reset held for 10 clocks
        rst_ni = 1'b0;
        n      = 0;
        repeat (10) begin
            @(negedge clk_i);
            check_model("reset");
        end
        rst_ni = 1'b1;
        n      = 0;
        check_model("release");

        // Two full frames from release, with aggregate counts alongside per-cycle checks
        tick_cnt = 0;
        hs_low   = 0;
        vs_low   = 0;
        fs_cnt   = 0;
        for (int i = 1; i <= 2 * FRAME * CLK_DIV; i++) begin
            step("run");
            if (i <= 40 && vga.p_tick === 1'b1) tick_cnt++;
            if (vga.hsync_n === 1'b0) hs_low++;
            if (vga.vsync_n === 1'b0) vs_low++;
            if (vga.frame_start === 1'b1) fs_cnt++;
        end
        chk("cadence_ticks_in_40", 10'(tick_cnt), 10'(41 / CLK_DIV));
        chk("hsync_low_clocks",    10'(hs_low),   10'(2 * V_TOTAL * H_SYNC * CLK_DIV));
        chk("vsync_low_clocks",    10'(vs_low),   10'(2 * V_SYNC * H_TOTAL * CLK_DIV));
        chk("frame_start_count",   10'(fs_cnt),   10'd2);

        // Random run lengths interrupted by asynchronous resets at random sub-cycle offsets
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(50, 900);
            for (int i = 0; i < len; i++) step("rand_run");
            #($urandom_range(1, 3));
            rst_ni = 1'b0;
            #1;
            n = 0;
            check_model("async_rst");
            hold = $urandom_range(1, 3);
            repeat (hold) begin
                @(negedge clk_i);
                check_model("rst_hold");
            end
            rst_ni = 1'b1;
            n      = 0;
            check_model("rst_release");
        end

        for (int i = 0; i < FRAME * CLK_DIV + 20; i++) step("final_run");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
